// File: rtl/sync_fifo_2_output_if.sv
// Handshake bundle for the dual-output synchronous FIFO: write side,
// two read lanes, and the occupancy/error status flags.
interface sync_fifo_2_output_if #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 wr_en;
    logic [DATAWIDTH-1:0] wr_data;
    logic                 rd_en;
    logic                 rd_en_2;
    logic [DATAWIDTH-1:0] rd_data;
    logic [DATAWIDTH-1:0] rd_data_2;
    logic                 rd_valid;
    logic                 rd_valid_2;
    logic                 full;
    logic                 empty;
    logic                 one_left;
    logic [CW-1:0]        count;
    logic                 wr_err;
    logic                 rd_err;

    // Producer/consumer side (drives requests, observes data and status)
    modport master (
        output wr_en, wr_data, rd_en, rd_en_2,
        input  rd_data, rd_data_2, rd_valid, rd_valid_2,
        input  full, empty, one_left, count, wr_err, rd_err
    );

    // FIFO side
    modport slave (
        input  wr_en, wr_data, rd_en, rd_en_2,
        output rd_data, rd_data_2, rd_valid, rd_valid_2,
        output full, empty, one_left, count, wr_err, rd_err
    );
endinterface

// File: rtl/sync_fifo_2_output.sv
// Synchronous FIFO with one write port and two read lanes. Lane 0 pops the
// oldest entry, lane 1 optionally pops the second-oldest in the same cycle.
// Read data is registered (one-cycle latency); there is no fall-through.
module sync_fifo_2_output #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8
) (
    input logic                 clk,
    input logic                 rst,
    sync_fifo_2_output_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATAWIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]        wr_ptr;
    logic [CW-1:0]        rd_ptr;
    logic [CW-1:0]        count_q;
    logic [DATAWIDTH-1:0] rd_data_q;
    logic [DATAWIDTH-1:0] rd_data_2_q;
    logic                 rd_valid_q;
    logic                 rd_valid_2_q;
    logic                 wr_err_q;
    logic                 rd_err_q;

    logic                 full_c;
    logic                 empty_c;
    logic                 one_left_c;
    logic                 wr_acc;
    logic                 wr_rej;
    logic [1:0]           pop_n;
    logic                 rd_err_c;
    logic [AW-1:0]        rd_idx0;
    logic [AW-1:0]        rd_idx1;

    // Status flags come from the registered count only, so they describe
    // the state before this cycle's requests are applied.
    assign full_c     = (count_q == CW'(DEPTH));
    assign empty_c    = (count_q == '0);
    assign one_left_c = (count_q == CW'(1));

    // Lane 1 reads the slot after lane 0; the AW-bit add wraps the index.
    assign rd_idx0 = rd_ptr[AW-1:0];
    assign rd_idx1 = rd_idx0 + AW'(1);

    // Grant decision: writes only when not full, pops limited by occupancy.
    always_comb begin
        wr_acc   = bus.wr_en & ~full_c;
        wr_rej   = bus.wr_en & full_c;
        pop_n    = 2'd0;
        if (bus.rd_en && bus.rd_en_2 && count_q >= CW'(2)) begin
            pop_n = 2'd2;
        end else if (bus.rd_en && !empty_c) begin
            pop_n = 2'd1;
        end
        rd_err_c = bus.rd_en & (empty_c | (bus.rd_en_2 & one_left_c));
    end

    // Storage write; entries are never cleared, reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= bus.wr_data;
        end
    end

    // Pointers, occupancy, registered read lanes and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            rd_data_q    <= '0;
            rd_data_2_q  <= '0;
            rd_valid_q   <= 1'b0;
            rd_valid_2_q <= 1'b0;
            wr_err_q     <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            rd_ptr       <= rd_ptr + CW'(pop_n);
            count_q      <= count_q + CW'(wr_acc) - CW'(pop_n);
            rd_valid_q   <= (pop_n != 2'd0);
            rd_valid_2_q <= (pop_n == 2'd2);
            if (pop_n != 2'd0) begin
                rd_data_q <= mem[rd_idx0];
            end
            if (pop_n == 2'd2) begin
                rd_data_2_q <= mem[rd_idx1];
            end
            wr_err_q <= wr_rej;
            rd_err_q <= rd_err_c;
        end
    end

    assign bus.full       = full_c;
    assign bus.empty      = empty_c;
    assign bus.one_left   = one_left_c;
    assign bus.count      = count_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_data_2  = rd_data_2_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_valid_2 = rd_valid_2_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.rd_err     = rd_err_q;
endmodule

// File: doc/sync_fifo_2_output.md
SYNC_FIFO_2_OUTPUT -- requirements
Module: sync_fifo_2_output

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 4.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  write request, one entry per cycle.
REQ-006 SHALL have port wr_data  input  DATAWIDTH  write data.
REQ-007 SHALL have port rd_en  input  1  pop request for lane 0 (oldest entry).
REQ-008 SHALL have port rd_en_2  input  1  pop request for lane 1 (second-oldest entry); qualifies only with rd_en.
REQ-009 SHALL have port rd_data  output  DATAWIDTH  lane 0 read data, registered.
REQ-010 SHALL have port rd_data_2  output  DATAWIDTH  lane 1 read data, registered.
REQ-011 SHALL have port rd_valid  output  1  lane 0 data valid pulse.
REQ-012 SHALL have port rd_valid_2  output  1  lane 1 data valid pulse.
REQ-013 SHALL have port full  output  1  count == DEPTH.
REQ-014 SHALL have port empty  output  1  count == 0.
REQ-015 SHALL have port one_left  output  1  count == 1.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port wr_err  output  1  one-cycle pulse on rejected write.
REQ-018 SHALL have port rd_err  output  1  one-cycle pulse when requested pops exceed occupancy.

Function
REQ-019 SHALL keep rd_ptr, wr_ptr of $clog2(DEPTH)+1 bits; low bits index memory, MSB toggles on wrap.
REQ-020 SHALL derive full/empty/one_left combinationally from registered count only (pre-update state).
REQ-021 SHALL accept write iff wr_en & !full; accepted write stores wr_data at mem[wr_ptr], wr_ptr+1.
REQ-022 SHALL reject write when wr_en & full: memory, wr_ptr unchanged; wr_err=1 next cycle; same-cycle pop does not free space for it.
REQ-023 SHALL grant pop count: rd_en & rd_en_2 & count>=2 -> 2; rd_en & count>=1 otherwise -> 1; else 0.
REQ-024 SHALL ignore rd_en_2 without rd_en (no pop, no rd_err).
REQ-025 SHALL raise rd_err next cycle when rd_en & empty, or rd_en & rd_en_2 & one_left (latter still pops 1).
REQ-026 SHALL on pop>=1 register rd_data<=mem[rd_ptr], rd_valid<=1; on pop==2 also rd_data_2<=mem[rd_ptr+1 mod DEPTH], rd_valid_2<=1.
REQ-027 SHALL have read latency exactly 1 cycle: data/valid appear the cycle after the granting edge.
REQ-028 SHALL drive rd_valid/rd_valid_2 low in cycles without a corresponding grant; rd_data/rd_data_2 hold last value.
REQ-029 SHALL advance rd_ptr by granted pop count, wrapping modulo 2*DEPTH.
REQ-030 SHALL update count <= count + write_accepted - pops in one cycle; simultaneous write and pop is legal.
REQ-031 SHALL not fall through: write into empty FIFO is not poppable in the same cycle.
REQ-032 SHALL never let count exceed DEPTH or go below 0.

Reset
REQ-033 SHALL on rst set wr_ptr, rd_ptr, count to 0; empty=1, full=0, one_left=0.
REQ-034 SHALL on rst set rd_data, rd_data_2 to 0 and rd_valid, rd_valid_2, wr_err, rd_err to 0.
REQ-035 SHALL give rst priority over all same-cycle requests; memory contents not reset; mid-operation reset discards all entries.

Verification
REQ-036 SHALL cover: write 0x11,0x22,0x33; rd_en&rd_en_2 -> next cycle rd_data=0x11, rd_data_2=0x22, both valid, count=1, one_left=1.
REQ-037 SHALL cover: count=1 (0x33), rd_en&rd_en_2 -> rd_data=0x33, rd_valid=1, rd_valid_2=0, rd_err=1, empty=1.
REQ-038 SHALL cover: fill 8 entries, wr_en with rd_en same cycle -> wr_err=1, count=7, written value absent.
REQ-039 SHALL cover: wrap -- 6 writes, 6 pops, 5 writes 0xA0..0xA4, dual pops -> ordered pairs (A0,A1),(A2,A3), then single A4.
REQ-040 SHALL cover: empty, wr_en=1 data 0x55 with rd_en=1 -> rd_err=1, no rd_valid, count=1; next-cycle rd_en returns 0x55.
REQ-041 SHALL cover: count=5, rst asserted with wr_en&rd_en -> next cycle count=0, empty=1, all valids and errs 0.
